// File: rtl/xor_hash_pkg.sv
// Shared types and default geometry for the XOR-hash table bank.
// Forwarding in xor_hash_bank_fwd is enabled by defining XOR_HASH_BANK_FWD_EN.
package xor_hash_pkg;

    localparam int DEF_NUM_MUL     = 4;
    localparam int DEF_INDEX_WIDTH = 12;
    localparam int DEF_DATA_WIDTH  = 64;
    localparam int DEF_WR_DELAY    = 3;
    localparam int DEF_RD_LATENCY  = 2;

    typedef logic [DEF_DATA_WIDTH-1:0] lane_word_t;

    // Counter step that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/xor_hash_uram_sdp.sv
// One RAM lane of the hash bank: simple dual-port, read-first, 1 or 2 cycle read latency.
module xor_hash_uram_sdp
    import xor_hash_pkg::*;
#(
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int RD_LATENCY  = DEF_RD_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [INDEX_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]  wdata,
    input  logic                   re,
    input  logic [INDEX_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]  rdata
);

    logic [DATA_WIDTH-1:0] mem_r [2**INDEX_WIDTH];
    logic [DATA_WIDTH-1:0] q0_r;

    // Array write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // First read register; sampling alongside the write gives read-first collisions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0_r <= {DATA_WIDTH{1'b0}};
        end else if (re) begin
            q0_r <= mem_r[raddr];
        end
    end

    if (RD_LATENCY >= 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] q1_r;

        // Second output register for the two-cycle configuration
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q1_r <= {DATA_WIDTH{1'b0}};
            end else begin
                q1_r <= q0_r;
            end
        end
        assign rdata = q1_r;
    end else begin : g_lat1
        assign rdata = q0_r;
    end

endmodule

// File: rtl/xor_hash_bank_fwd.sv
// Multi-lane XOR-hash bank with write pipeline and optional per-lane read forwarding.
// Define XOR_HASH_BANK_FWD_EN to build the forwarding unit; otherwise reads see raw RAM.
module xor_hash_bank_fwd
    import xor_hash_pkg::*;
#(
    parameter int NUM_MUL     = DEF_NUM_MUL,
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int WR_DELAY    = DEF_WR_DELAY,
    parameter int RD_LATENCY  = DEF_RD_LATENCY
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_valid,
    input  logic [INDEX_WIDTH-1:0]        wr_index,
    input  logic [NUM_MUL-1:0]            wr_lane_en,
    input  logic [NUM_MUL*DATA_WIDTH-1:0] wr_data,
    input  logic                          rd_valid,
    input  logic [INDEX_WIDTH-1:0]        rd_index,
    output logic                          rd_out_valid,
    output logic [NUM_MUL*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_MUL-1:0]            rd_fwd_hit,
    output logic [31:0]                   fwd_count
);

    localparam int WL = WR_DELAY - 1;
    localparam int RL = RD_LATENCY - 1;

    logic                          wv_r    [WR_DELAY];
    logic [INDEX_WIDTH-1:0]        widx_r  [WR_DELAY];
    logic [NUM_MUL-1:0]            wlane_r [WR_DELAY];
    logic [NUM_MUL*DATA_WIDTH-1:0] wdata_r [WR_DELAY];
    logic                          rv_r    [RD_LATENCY];
    logic [DATA_WIDTH-1:0]         ram_q_s [NUM_MUL];

    // Accepted writes march toward the commit stage; reset discards them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < WR_DELAY; s++) begin
                wv_r[s]    <= 1'b0;
                widx_r[s]  <= {INDEX_WIDTH{1'b0}};
                wlane_r[s] <= {NUM_MUL{1'b0}};
                wdata_r[s] <= {(NUM_MUL*DATA_WIDTH){1'b0}};
            end
        end else begin
            wv_r[0]    <= wr_valid;
            widx_r[0]  <= wr_index;
            wlane_r[0] <= wr_lane_en;
            wdata_r[0] <= wr_data;
            for (int s = 1; s < WR_DELAY; s++) begin
                wv_r[s]    <= wv_r[s-1];
                widx_r[s]  <= widx_r[s-1];
                wlane_r[s] <= wlane_r[s-1];
                wdata_r[s] <= wdata_r[s-1];
            end
        end
    end

    // Read-valid pipeline matched to the RAM latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                rv_r[s] <= 1'b0;
            end
        end else begin
            rv_r[0] <= rd_valid;
            for (int s = 1; s < RD_LATENCY; s++) begin
                rv_r[s] <= rv_r[s-1];
            end
        end
    end

    for (genvar i = 0; i < NUM_MUL; i++) begin : g_lane
        xor_hash_uram_sdp #(
            .INDEX_WIDTH (INDEX_WIDTH),
            .DATA_WIDTH  (DATA_WIDTH),
            .RD_LATENCY  (RD_LATENCY)
        ) u_ram (
            .clk   (clk),
            .rst_n (reset),
            .we    (wv_r[WL] & wlane_r[WL][i]),
            .waddr (widx_r[WL]),
            .wdata (wdata_r[WL][i*DATA_WIDTH +: DATA_WIDTH]),
            .re    (rd_valid),
            .raddr (rd_index),
            .rdata (ram_q_s[i])
        );
    end

    assign rd_out_valid = rv_r[RL];

`ifdef XOR_HASH_BANK_FWD_EN
    logic [NUM_MUL-1:0]            hit_s;
    logic [NUM_MUL*DATA_WIDTH-1:0] fwd_s;
    logic [NUM_MUL-1:0]            hit_r   [RD_LATENCY];
    logic [NUM_MUL*DATA_WIDTH-1:0] fdata_r [RD_LATENCY];
    logic [31:0]                   fwd_count_r;

    // Oldest stage first so a younger per-lane match overwrites an older one
    always_comb begin
        hit_s = {NUM_MUL{1'b0}};
        fwd_s = {(NUM_MUL*DATA_WIDTH){1'b0}};
        for (int i = 0; i < NUM_MUL; i++) begin
            for (int s = WR_DELAY - 1; s >= 0; s--) begin
                if (wv_r[s] && (widx_r[s] == rd_index) && wlane_r[s][i]) begin
                    hit_s[i]                         = 1'b1;
                    fwd_s[i*DATA_WIDTH +: DATA_WIDTH] = wdata_r[s][i*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    hit_s[i] = hit_s[i];
                end
            end
        end
    end

    // Forward data is frozen at issue and travels beside the RAM read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                hit_r[s]   <= {NUM_MUL{1'b0}};
                fdata_r[s] <= {(NUM_MUL*DATA_WIDTH){1'b0}};
            end
        end else begin
            hit_r[0]   <= rd_valid ? hit_s : {NUM_MUL{1'b0}};
            fdata_r[0] <= fwd_s;
            for (int s = 1; s < RD_LATENCY; s++) begin
                hit_r[s]   <= hit_r[s-1];
                fdata_r[s] <= fdata_r[s-1];
            end
        end
    end

    // Saturating count of delivered reads that used any forwarded lane
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_count_r <= 32'd0;
        end else if (rv_r[RL] && (|hit_r[RL])) begin
            fwd_count_r <= sat_inc32(fwd_count_r);
        end else begin
            fwd_count_r <= fwd_count_r;
        end
    end

    // Per-lane output select between forwarded and RAM data
    always_comb begin
        rd_data = {(NUM_MUL*DATA_WIDTH){1'b0}};
        for (int i = 0; i < NUM_MUL; i++) begin
            if (hit_r[RL][i]) begin
                rd_data[i*DATA_WIDTH +: DATA_WIDTH] = fdata_r[RL][i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                rd_data[i*DATA_WIDTH +: DATA_WIDTH] = ram_q_s[i];
            end
        end
    end

    assign rd_fwd_hit = hit_r[RL];
    assign fwd_count  = fwd_count_r;
`else
    // Raw RAM data straight through when forwarding is not built
    always_comb begin
        rd_data = {(NUM_MUL*DATA_WIDTH){1'b0}};
        for (int i = 0; i < NUM_MUL; i++) begin
            rd_data[i*DATA_WIDTH +: DATA_WIDTH] = ram_q_s[i];
        end
    end

    assign rd_fwd_hit = {NUM_MUL{1'b0}};
    assign fwd_count  = 32'd0;
`endif

endmodule

// File: tb/tb_xor_hash_bank_fwd.sv
// Randomized and directed bench for xor_hash_bank_fwd against a logical-memory model.
// Expectations follow XOR_HASH_BANK_FWD_EN the same way the design does.
module tb_xor_hash_bank_fwd;
    import xor_hash_pkg::*;

    localparam int NM  = 4;
    localparam int IW  = 12;
    localparam int DW  = 64;
    localparam int WRD = 3;
    localparam int RDL = 2;
`ifdef XOR_HASH_BANK_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            wr_valid;
    logic [IW-1:0]   wr_index;
    logic [NM-1:0]   wr_lane_en;
    logic [NM*DW-1:0] wr_data;
    logic            rd_valid;
    logic [IW-1:0]   rd_index;
    logic            rd_out_valid;
    logic [NM*DW-1:0] rd_data;
    logic [NM-1:0]   rd_fwd_hit;
    logic [31:0]     fwd_count;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    xor_hash_bank_fwd #(
        .NUM_MUL(NM), .INDEX_WIDTH(IW), .DATA_WIDTH(DW), .WR_DELAY(WRD), .RD_LATENCY(RDL)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_index(wr_index), .wr_lane_en(wr_lane_en), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_index(rd_index),
        .rd_out_valid(rd_out_valid), .rd_data(rd_data), .rd_fwd_hit(rd_fwd_hit), .fwd_count(fwd_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic vld; logic [IW-1:0] idx; logic [NM-1:0] lane; logic [NM*DW-1:0] data; } wrec_t;
    typedef struct { logic vld; logic [NM*DW-1:0] data; logic [NM-1:0] hit; } rexp_t;

    lane_word_t  ram_mem [NM][2**IW];
    wrec_t       hist[$];
    rexp_t       expq[$];
    logic [31:0] exp_cnt;

    task automatic check(input string name, input logic [NM*DW-1:0] act, input logic [NM*DW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    function automatic lane_word_t init_word(input int idx, input int lane);
        return {16'hC0DE, 8'(lane), 8'h00, 20'(idx), 12'h123};
    endfunction

    function automatic logic [NM*DW-1:0] init_row(input int idx);
        logic [NM*DW-1:0] r;
        for (int l = 0; l < NM; l++) r[l*DW +: DW] = init_word(idx, l);
        return r;
    endfunction

    function automatic logic [NM*DW-1:0] rand_row();
        logic [NM*DW-1:0] r;
        for (int k = 0; k < NM*2; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Model: RAM holds writes older than WRD cycles; a read sees RAM overlaid with
    // the in-flight writes (youngest wins per lane) when forwarding exists.
    initial begin : model
        for (int l = 0; l < NM; l++)
            for (int a = 0; a < 2**IW; a++) ram_mem[l][a] = '0;
        exp_cnt = 32'd0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                hist.delete();
                expq.delete();
                exp_cnt = 32'd0;
            end else begin
                rexp_t e;
                wrec_t w;
                if (expq.size() == RDL && expq[0].vld && (|expq[0].hit) && exp_cnt != 32'hFFFF_FFFF)
                    exp_cnt = exp_cnt + 32'd1;
                e.vld = rd_valid; e.data = '0; e.hit = '0;
                if (rd_valid) begin
                    for (int l = 0; l < NM; l++) begin
                        lane_word_t v = ram_mem[l][rd_index];
                        logic h = 1'b0;
                        foreach (hist[k])
                            if (hist[k].vld && hist[k].idx == rd_index && hist[k].lane[l]) begin
                                v = hist[k].data[l*DW +: DW];
                                h = 1'b1;
                            end
                        e.data[l*DW +: DW] = FWD ? v : ram_mem[l][rd_index];
                        e.hit[l] = FWD ? h : 1'b0;
                    end
                end
                expq.push_back(e);
                if (expq.size() > RDL) void'(expq.pop_front());
                w.vld = wr_valid; w.idx = wr_index; w.lane = wr_lane_en; w.data = wr_data;
                hist.push_back(w);
                if (hist.size() > WRD) begin
                    w = hist.pop_front();
                    if (w.vld)
                        for (int l = 0; l < NM; l++)
                            if (w.lane[l]) ram_mem[l][w.idx] = w.data[l*DW +: DW];
                end
            end
        end
    end

    // Every-cycle comparison of outputs against the model
    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (!reset) begin
                    check("rst_valid", 256'(rd_out_valid), 256'(0));
                    check("rst_data", rd_data, '0);
                    check("rst_cnt", 256'(fwd_count), 256'(0));
                end else begin
                    logic ev;
                    ev = (expq.size() == RDL) && expq[0].vld;
                    check("out_valid", 256'(rd_out_valid), 256'(ev));
                    if (ev) begin
                        check("out_data", rd_data, expq[0].data);
                        check("out_hit", 256'(rd_fwd_hit), 256'(expq[0].hit));
                    end
                    check("fwd_count", 256'(fwd_count), 256'(exp_cnt));
                end
            end
        end
    end

    task automatic drive(input logic wv, input int wi, input logic [NM-1:0] wl,
                         input logic [NM*DW-1:0] wd, input logic rv, input int ri);
        wr_valid = wv; wr_index = IW'(wi); wr_lane_en = wl; wr_data = wd;
        rd_valid = rv; rd_index = IW'(ri);
        @(posedge clk); #1;
        wr_valid = 1'b0; rd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, '0, '0, 1'b0, 0);
    endtask

    task automatic wait_out(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_out_valid && n < 10);
        if (!rd_out_valid) check({name, "_timeout"}, 256'(rd_out_valid), 256'(1));
    endtask

    initial begin : driver
        int n;
        logic [NM*DW-1:0] x_row, y_row, exp3;
        reset = 1'b1; wr_valid = 1'b0; wr_index = '0; wr_lane_en = '0; wr_data = '0;
        rd_valid = 1'b0; rd_index = '0;
        #2 reset = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Fill the whole RAM with known contents
        for (int i = 0; i < 2**IW; i++) drive(1'b1, i, 4'hF, init_row(i), 1'b0, 0);
        idle(WRD + 1);

        // Committed write read back after it has landed
        drive(1'b1, 5, 4'hF, {4{64'hAAAA_AAAA_AAAA_AAAA}}, 1'b0, 0);
        idle(WRD);
        drive(1'b0, 0, '0, '0, 1'b1, 5);
        wait_out("t1", n);
        check("t1_latency", 256'(n), 256'(RDL));
        check("t1_data", rd_data, {4{64'hAAAA_AAAA_AAAA_AAAA}});
        check("t1_hit", 256'(rd_fwd_hit), 256'(0));

        // Read one cycle behind a full-lane write
        drive(1'b1, 7, 4'hF, {64'hD0D0_0000_0000_0003, 64'hD0D0_0000_0000_0002,
                              64'hD0D0_0000_0000_0001, 64'hD0D0_0000_0000_0000}, 1'b0, 0);
        drive(1'b0, 0, '0, '0, 1'b1, 7);
        wait_out("t2", n);
        check("t2_data", rd_data, FWD ? {64'hD0D0_0000_0000_0003, 64'hD0D0_0000_0000_0002,
                                         64'hD0D0_0000_0000_0001, 64'hD0D0_0000_0000_0000} : init_row(7));
        check("t2_hit", 256'(rd_fwd_hit), FWD ? 256'(4'hF) : 256'(0));
        @(negedge clk);
        check("t2_count", 256'(fwd_count), FWD ? 256'(1) : 256'(0));

        // Per-lane youngest-match selection across two partial writes
        x_row = {4{64'h5555_0000_0000_0009}};
        y_row = {4{64'h7777_0000_0000_0009}};
        drive(1'b1, 9, 4'b0011, x_row, 1'b0, 0);
        drive(1'b1, 9, 4'b0110, y_row, 1'b0, 0);
        drive(1'b0, 0, '0, '0, 1'b1, 9);
        wait_out("t3", n);
        exp3 = {init_word(9, 3), 64'h7777_0000_0000_0009, 64'h7777_0000_0000_0009, 64'h5555_0000_0000_0009};
        check("t3_data", rd_data, FWD ? exp3 : init_row(9));
        check("t3_hit", 256'(rd_fwd_hit), FWD ? 256'(4'b0111) : 256'(0));
        @(negedge clk);
        check("t3_count", 256'(fwd_count), FWD ? 256'(2) : 256'(0));
        idle(WRD + 1);

        // Same-cycle write and read of one index returns the old value
        drive(1'b1, 3, 4'hF, {4{64'hBEEF_0000_0000_0003}}, 1'b1, 3);
        wait_out("t4", n);
        check("t4_data", rd_data, init_row(3));
        check("t4_hit", 256'(rd_fwd_hit), 256'(0));
        idle(WRD + 1);

        // Reset with two writes and a read in flight
        drive(1'b1, 20, 4'hF, {4{64'h2020_2020_2020_2020}}, 1'b1, 5);
        drive(1'b1, 21, 4'hF, {4{64'h2121_2121_2121_2121}}, 1'b0, 0);
        check("t5_pre_valid", 256'(rd_out_valid), 256'(1));
        reset = 1'b0;
        #1;
        check("t5_rst_valid", 256'(rd_out_valid), 256'(0));
        check("t5_rst_data", rd_data, '0);
        check("t5_rst_hit", 256'(rd_fwd_hit), 256'(0));
        check("t5_rst_count", 256'(fwd_count), 256'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        drive(1'b0, 0, '0, '0, 1'b1, 20);
        wait_out("t5a", n);
        check("t5_idx20", rd_data, init_row(20));
        drive(1'b0, 0, '0, '0, 1'b1, 21);
        wait_out("t5b", n);
        check("t5_idx21", rd_data, init_row(21));
        check("t5_hit", 256'(rd_fwd_hit), 256'(0));
        idle(WRD + 1);

        // Back-to-back sweep with the read one cycle behind the write
        for (int i = 0; i <= 2**IW; i++)
            drive(i < 2**IW, i % (2**IW), 4'hF, rand_row(), i > 0, i - 1);

        // Random traffic over a small index window to provoke hazards
        for (int k = 0; k < 3000; k++)
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  rand_row(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));

        idle(RDL + WRD + 2);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/xor_hash_bank_fwd.md
# xor_hash_bank_fwd

Multi-lane XOR-hash table bank: NUM_MUL independent RAM lanes sharing one write index and one read index, with a configurable-depth write pipeline and configurable read latency. Sits between the arbiter/XOR-update datapath and the hash-lookup stage. Read-after-write hazards against in-flight writes are resolved by an optional per-lane forwarding unit, so a read returns the value as if every earlier-accepted write had already landed.

## Interface
- NUM_MUL, 4: number of lanes (RAM instances).
- INDEX_WIDTH, 12: address width; depth = 2**INDEX_WIDTH.
- DATA_WIDTH, 64: per-lane word width.
- WR_DELAY, 3: write pipeline stages from acceptance to RAM commit (≥1).
- RD_LATENCY, 2: RAM read latency in cycles (1 or 2).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_valid  in  1  write request accepted this cycle.
- wr_index  in  INDEX_WIDTH  write address.
- wr_lane_en  in  NUM_MUL  per-lane write enable (arbiter result).
- wr_data  in  NUM_MUL*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- rd_valid  in  1  read request issued this cycle.
- rd_index  in  INDEX_WIDTH  read address.
- rd_out_valid  out  1  rd_data valid.
- rd_data  out  NUM_MUL*DATA_WIDTH  read result per lane.
- rd_fwd_hit  out  NUM_MUL  lane i of rd_data came from forwarding.
- fwd_count  out  32  saturating count of reads with any forward hit.

## Operation
- Write accepted at cycle t travels WR_DELAY stages (valid, index, lane_en, data); commits at t+WR_DELAY to every lane with lane_en set. Stage with valid=0 never commits.
- RAM: simple dual-port, read-first on same-address collision.
- Required read semantics: read issued at t returns, per lane, the youngest write accepted in cycles < t with that lane enabled at that index; writes accepted at t are not visible.
- Forwarding: at issue, compare rd_index against every valid write-pipeline stage (the WR_DELAY writes accepted in t-WR_DELAY..t-1); per lane pick youngest match with lane_en[i]=1. Lanes independent: a younger match with lane_en[i]=0 does not mask an older match with lane_en[i]=1.
- Selected forward data and hit bits ride the read pipeline; at output, lane i = hit ? forward data : RAM data. Forward data captured at issue; later writes do not alter an issued read.
- fwd_count increments when rd_out_valid and |rd_fwd_hit; holds at 2**32-1.
- Simultaneous read and write, any addresses, every cycle: fully supported, no stall, no backpressure.

## Timing
- Write throughput 1/cycle; read throughput 1/cycle.
- Read latency RD_LATENCY cycles: rd_valid at t -> rd_out_valid at t+RD_LATENCY.
- Reset (async assert, sync release): write-pipeline valids, read-pipeline valids, rd_out_valid, rd_fwd_hit, fwd_count -> 0; rd_data -> 0. RAM contents not cleared.
- Reset mid-operation: in-flight writes discarded (never commit), in-flight reads dropped; first cycle after release accepts new requests.
- Index wrap: none; all 2**INDEX_WIDTH addresses valid.

## Configuration
- XOR_HASH_BANK_FWD_EN defined: forwarding unit built as above.
- Undefined: no comparators; rd_data = raw RAM data, rd_fwd_hit and fwd_count tied 0; reads of uncommitted addresses return stale values (caller must space RAW by ≥WR_DELAY+1 cycles).

## Structure
- Shared package xor_hash_pkg: lane-word typedef, default widths, WR_DELAY/RD_LATENCY defaults.
- One sub-module: xor_hash_uram_sdp (one RAM lane, parametrised RD_LATENCY, read-first), instantiated NUM_MUL times. Forward selection stays in the top.

## Test plan
- Write idx 5 lanes 1111 data 0xA.. per lane at t; read idx 5 at t+WR_DELAY+1 -> rd_out_valid at +RD_LATENCY, all lanes 0xA.., rd_fwd_hit=0000.
- Write idx 7 data D0 at t, read idx 7 at t+1 (FWD_EN) -> all lanes D0, rd_fwd_hit=1111, fwd_count=1; without FWD_EN -> prior RAM value.
- Writes idx 9: t lane_en 0011 data X, t+1 lane_en 0110 data Y; read idx 9 at t+2 -> lanes0..3 = X,Y,Y,old; hit=0111.
- Write and read idx 3 same cycle -> old value returned, hit=0000.
- Back-to-back writes/reads idx 0..4095 each cycle, read lags write by 1 -> every read returns just-written data vs. scoreboard.
- Assert reset with 2 writes in flight -> outputs 0 immediately; after release read those indices -> pre-write values.
